// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi survivor-memory bank scheduler:
// lifecycle state encoding, bank indices and the default address width.
package viterbi_pkg;

    localparam int AW_DEFAULT = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } sched_state_t;

    localparam logic [1:0] BANK_A = 2'd0;
    localparam logic [1:0] BANK_B = 2'd1;
    localparam logic [1:0] BANK_C = 2'd2;
    localparam logic [1:0] BANK_D = 2'd3;

endpackage

// File: rtl/bank_role_map.sv
// Combinational bank-role decode: from the current write bank, derive the two
// read banks, the idle bank and the two banks feeding the traceback units.
module bank_role_map
    import viterbi_pkg::*;
(
    input  logic [1:0] wb,
    output logic [1:0] rd_bank0,
    output logic [1:0] rd_bank1,
    output logic [1:0] idle_bank,
    output logic [1:0] tb_bank0,
    output logic [1:0] tb_bank1
);

    // 2-bit adds wrap modulo 4, which is exactly the ring of four banks.
    always_comb begin
        rd_bank0  = wb + 2'd1;
        rd_bank1  = wb + 2'd3;
        idle_bank = wb + 2'd2;
        tb_bank0  = wb + 2'd3;
        tb_bank1  = wb[0] ? (wb + 2'd1) : (wb + 2'd2);
    end

endmodule

// File: rtl/viterbi_bank_sched.sv
// Four-bank trellis survivor memory scheduler: rotating write/read/idle roles,
// traceback enables/selects and an IDLE/FILL/RUN/DRAIN stream lifecycle.
// Define VITERBI_SCHED_BLKCNT_EN to add the 16-bit blk_cnt output.
module viterbi_bank_sched
    import viterbi_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic            stop,
    output logic [3:0]      mem_wr,
    output logic [4*AW-1:0] mem_addr,
    output logic [1:0]      tb_bank0,
    output logic [1:0]      tb_bank1,
    output logic [1:0]      tbu_en,
    output logic [1:0]      tbu_sel,
    output logic            disp_sel,
    output logic            busy,
    output logic            done
`ifdef VITERBI_SCHED_BLKCNT_EN
    ,
    output logic [15:0]     blk_cnt
`endif
);

    sched_state_t    state_q, state_d;
    logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [1:0]      wb_q, wb_d;
    logic [1:0]      fill_q, fill_d;
    logic            drain_cnt_q, drain_cnt_d;
    logic            done_q, done_d;
    logic [3:0]      mem_wr_q, mem_wr_d;
    logic [4*AW-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]      tb_bank0_q, tb_bank0_d;
    logic [1:0]      tb_bank1_q, tb_bank1_d;
    logic [1:0]      tbu_sel_q, tbu_sel_d;
    logic [2:0]      disp_pipe_q, disp_pipe_d;
`ifdef VITERBI_SCHED_BLKCNT_EN
    logic [15:0]     blk_cnt_q, blk_cnt_d;
`endif

    logic            step;
    logic            wrap;
    logic [AW-1:0]   rd_cnt;
    logic [1:0]      rd_bank0, rd_bank1, idle_bank, map_tb0, map_tb1;

    bank_role_map u_role_map (
        .wb        (wb_q),
        .rd_bank0  (rd_bank0),
        .rd_bank1  (rd_bank1),
        .idle_bank (idle_bank),
        .tb_bank0  (map_tb0),
        .tb_bank1  (map_tb1)
    );

    assign rd_cnt = ~wr_cnt_q;
    assign step   = (state_q == S_DRAIN) ||
                    (in_valid && ((state_q == S_FILL) || (state_q == S_RUN)));
    assign wrap   = step && (wr_cnt_q == '1);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        wb_d        = wb_q;
        fill_d      = fill_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        disp_pipe_d = {disp_pipe_q[1:0], wb_q[0]};
`ifdef VITERBI_SCHED_BLKCNT_EN
        blk_cnt_d   = blk_cnt_q;
        if (wrap && (state_q != S_DRAIN)) blk_cnt_d = blk_cnt_q + 16'd1;
`endif

        if (step) wr_cnt_d = wr_cnt_q + AW'(1);
        if (wrap) begin
            wb_d   = wb_q + 2'd1;
            fill_d = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FILL;
                    wr_cnt_d    = '0;
                    wb_d        = BANK_A;
                    fill_d      = 2'd0;
                    drain_cnt_d = 1'b0;
`ifdef VITERBI_SCHED_BLKCNT_EN
                    blk_cnt_d   = 16'd0;
`endif
                end
            end
            S_FILL, S_RUN: begin
                // A stop on the wrap cycle keeps the wrap but does not count it as a drain wrap.
                if (stop) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 1'b0;
                end else if ((state_q == S_FILL) && wrap && (fill_q == 2'd2)) begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (wrap) begin
                    if (drain_cnt_q) begin
                        state_d = S_IDLE;
                        fill_d  = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        drain_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory-side outputs are registered from the pre-step position; IDLE shows reset values.
    always_comb begin
        mem_wr_d   = '0;
        mem_addr_d = '0;
        tb_bank0_d = BANK_D;
        tb_bank1_d = BANK_C;
        tbu_sel_d  = 2'b10;
        if (state_q != S_IDLE) begin
            mem_wr_d[wb_q]                          = step && (state_q != S_DRAIN);
            mem_addr_d[int'(wb_q)*AW +: AW]         = wr_cnt_q;
            mem_addr_d[int'(rd_bank0)*AW +: AW]     = rd_cnt;
            mem_addr_d[int'(rd_bank1)*AW +: AW]     = rd_cnt;
            mem_addr_d[int'(idle_bank)*AW +: AW]    = '0;
            tb_bank0_d = map_tb0;
            tb_bank1_d = map_tb1;
            tbu_sel_d  = {~wb_q[0], wb_q[0]};
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_cnt_q    <= '0;
            wb_q        <= BANK_A;
            fill_q      <= 2'd0;
            drain_cnt_q <= 1'b0;
            done_q      <= 1'b0;
            mem_wr_q    <= '0;
            mem_addr_q  <= '0;
            tb_bank0_q  <= BANK_D;
            tb_bank1_q  <= BANK_C;
            tbu_sel_q   <= 2'b10;
            disp_pipe_q <= '0;
`ifdef VITERBI_SCHED_BLKCNT_EN
            blk_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            wb_q        <= wb_d;
            fill_q      <= fill_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            tb_bank0_q  <= tb_bank0_d;
            tb_bank1_q  <= tb_bank1_d;
            tbu_sel_q   <= tbu_sel_d;
            disp_pipe_q <= disp_pipe_d;
`ifdef VITERBI_SCHED_BLKCNT_EN
            blk_cnt_q   <= blk_cnt_d;
`endif
        end
    end

    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign tb_bank0 = tb_bank0_q;
    assign tb_bank1 = tb_bank1_q;
    assign tbu_en   = {fill_q == 2'd3, fill_q >= 2'd2};
    assign tbu_sel  = tbu_sel_q;
    assign disp_sel = disp_pipe_q[2];
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
`ifdef VITERBI_SCHED_BLKCNT_EN
    assign blk_cnt  = blk_cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_bank_sched.sv
// Self-checking bench for viterbi_bank_sched: directed stream scenarios checked
// every cycle against a position/role model, plus hand-computed literal points.
module tb_viterbi_bank_sched;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            stop = 1'b0;
    logic [3:0]      mem_wr;
    logic [4*AW-1:0] mem_addr;
    logic [1:0]      tb_bank0, tb_bank1, tbu_en, tbu_sel;
    logic            disp_sel, busy, done;
`ifdef VITERBI_SCHED_BLKCNT_EN
    logic [15:0]     blk_cnt;
`endif

    viterbi_bank_sched #(.AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .stop     (stop),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .tb_bank0 (tb_bank0),
        .tb_bank1 (tb_bank1),
        .tbu_en   (tbu_en),
        .tbu_sel  (tbu_sel),
        .disp_sel (disp_sel),
        .busy     (busy),
        .done     (done)
`ifdef VITERBI_SCHED_BLKCNT_EN
        ,
        .blk_cnt  (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: stream position (bank, offset), lifecycle phase, wrap counts.
    int m_state = 0;  // 0 idle, 1 fill, 2 run, 3 drain
    int m_wr = 0, m_wb = 0, m_fill = 0, m_drain_wraps = 0, m_blk = 0;
    int wb_hist [4] = '{0, 0, 0, 0};
    logic [3:0]      e_mem_wr = '0;
    logic [4*AW-1:0] e_addr = '0;
    logic [1:0]      e_tb0 = 2'd3, e_tb1 = 2'd2, e_tbu_en = '0, e_tbu_sel = 2'b10;
    logic            e_disp = 1'b0, e_busy = 1'b0, e_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit m_step, m_wrap;
        if (rst) begin
            m_state = 0; m_wr = 0; m_wb = 0; m_fill = 0; m_drain_wraps = 0; m_blk = 0;
            wb_hist = '{0, 0, 0, 0};
            e_mem_wr = '0; e_addr = '0; e_tb0 = 2'd3; e_tb1 = 2'd2;
            e_tbu_en = '0; e_tbu_sel = 2'b10; e_disp = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            m_step = ((m_state == 1 || m_state == 2) && in_valid) || (m_state == 3);
            m_wrap = m_step && (m_wr == DEPTH - 1);
            e_mem_wr = '0; e_addr = '0; e_tb0 = 2'd3; e_tb1 = 2'd2; e_tbu_sel = 2'b10;
            if (m_state != 0) begin
                for (int k = 0; k < 4; k++) begin
                    int role;
                    role = (k - m_wb + 4) % 4;
                    if (role == 0)      e_addr[k*AW +: AW] = AW'(m_wr);
                    else if (role == 2) e_addr[k*AW +: AW] = '0;
                    else                e_addr[k*AW +: AW] = AW'(DEPTH - 1 - m_wr);
                end
                e_mem_wr[m_wb] = m_step && (m_state != 3);
                e_tb0 = 2'((m_wb + 3) % 4);
                e_tb1 = (m_wb % 2 == 1) ? 2'((m_wb + 1) % 4) : 2'((m_wb + 2) % 4);
                e_tbu_sel = (m_wb % 2 == 1) ? 2'b01 : 2'b10;
            end
            e_done = 1'b0;
            if (m_wrap && m_state != 3) m_blk = (m_blk + 1) % 65536;
            if (m_step) begin
                m_wr = (m_wr + 1) % DEPTH;
                if (m_wrap) begin
                    m_wb = (m_wb + 1) % 4;
                    if (m_fill < 3) m_fill++;
                end
            end
            case (m_state)
                0: if (start) begin
                    m_state = 1; m_wr = 0; m_wb = 0; m_fill = 0; m_drain_wraps = 0; m_blk = 0;
                end
                1, 2: if (stop) begin
                    m_state = 3; m_drain_wraps = 0;
                end else if (m_state == 1 && m_wrap && m_fill == 3) begin
                    m_state = 2;
                end
                default: if (m_wrap) begin
                    m_drain_wraps++;
                    if (m_drain_wraps == 2) begin
                        m_state = 0; m_fill = 0; e_done = 1'b1;
                    end
                end
            endcase
            wb_hist[3] = wb_hist[2]; wb_hist[2] = wb_hist[1]; wb_hist[1] = wb_hist[0];
            wb_hist[0] = m_wb;
            e_disp   = wb_hist[3][0];
            e_tbu_en = {m_fill == 3, m_fill >= 2};
            e_busy   = (m_state != 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("mem_wr",   mem_wr,   e_mem_wr);
            check("mem_addr", mem_addr, e_addr);
            check("tb_bank0", tb_bank0, e_tb0);
            check("tb_bank1", tb_bank1, e_tb1);
            check("tbu_en",   tbu_en,   e_tbu_en);
            check("tbu_sel",  tbu_sel,  e_tbu_sel);
            check("disp_sel", disp_sel, e_disp);
            check("busy",     busy,     e_busy);
            check("done",     done,     e_done);
`ifdef VITERBI_SCHED_BLKCNT_EN
            check("blk_cnt",  blk_cnt,  m_blk);
`endif
        end
    end

    task automatic cycles(input logic s, input logic v, input logic p, input int n);
        for (int i = 0; i < n; i++) begin
            start = s; in_valid = v; stop = p;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; stop = 1'b0;
    endtask

    // Counts cycles from the stop cycle until done, hammering ignored inputs meanwhile.
    task automatic wait_done(input string name, input int exp_cyc);
        int c;
        c = 1;
        while (!done && c < 5000) begin
            start = (c % 7 == 0); stop = (c % 5 == 0); in_valid = c[0];
            @(negedge clk);
            c++;
        end
        start = 1'b0; in_valid = 1'b0; stop = 1'b0;
        check(name, c, exp_cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_wr"},   mem_wr,   4'd0);
        check({tag, "_mem_addr"}, mem_addr, '0);
        check({tag, "_tb_bank0"}, tb_bank0, 2'd3);
        check({tag, "_tb_bank1"}, tb_bank1, 2'd2);
        check({tag, "_tbu_en"},   tbu_en,   2'd0);
        check({tag, "_tbu_sel"},  tbu_sel,  2'b10);
        check({tag, "_disp_sel"}, disp_sel, 1'b0);
        check({tag, "_busy"},     busy,     1'b0);
        check({tag, "_done"},     done,     1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Stream start and addressing at wb=0, wr_cnt=5.
        cycles(1'b1, 1'b0, 1'b0, 1);
        check("busy_after_start", busy, 1'b1);
        cycles(1'b0, 1'b1, 1'b0, 5);
        cycles(1'b0, 1'b1, 1'b0, 1);
        check("addr_mem_wr", mem_wr, 4'b0001);
        check("addr_bank_a", mem_addr[0*AW +: AW], 10'd5);
        check("addr_bank_b", mem_addr[1*AW +: AW], 10'd1018);
        check("addr_bank_c", mem_addr[2*AW +: AW], 10'd0);
        check("addr_bank_d", mem_addr[3*AW +: AW], 10'd1018);

        // Gapped valid: one in three.
        for (int g = 0; g < 3; g++) begin
            cycles(1'b0, 1'b1, 1'b0, 1);
            check("gap_pulse", mem_wr, 4'b0001);
            cycles(1'b0, 1'b0, 1'b0, 2);
            check("gap_idle", mem_wr, 4'b0000);
        end
        check("gap_addr_a", mem_addr[0*AW +: AW], 10'd9);

        // Fill progression through the 2nd and 3rd wraps.
        cycles(1'b0, 1'b1, 1'b0, 2038);
        check("fill_before_wrap2", tbu_en, 2'b00);
        cycles(1'b0, 1'b1, 1'b0, 1);
        check("fill_after_wrap2", tbu_en, 2'b01);
        cycles(1'b0, 1'b1, 1'b0, 1023);
        check("fill_before_wrap3", tbu_en, 2'b01);
        cycles(1'b0, 1'b1, 1'b0, 1);
        check("fill_after_wrap3", tbu_en, 2'b11);
        cycles(1'b0, 1'b1, 1'b0, 1);
        check("run_wb3_mem_wr", mem_wr, 4'b1000);
        check("run_wb3_tbu_sel", tbu_sel, 2'b01);
        check("run_wb3_tb_bank0", tb_bank0, 2'd2);
        check("run_wb3_tb_bank1", tb_bank1, 2'd0);

        // Stop in RUN at wr_cnt=100 with a valid vector present.
        cycles(1'b0, 1'b1, 1'b0, 99);
        cycles(1'b0, 1'b1, 1'b1, 1);
        wait_done("drain_len_run_stop", 1948);
        check("done_busy_low", busy, 1'b0);
        cycles(1'b0, 1'b0, 1'b0, 1);
        check("done_single_pulse", done, 1'b0);

        // Stop and in_valid ignored in IDLE.
        cycles(1'b0, 1'b1, 1'b1, 4);
        check("idle_ignores_stop", busy, 1'b0);

        // Stop coincident with a wrap in FILL.
        cycles(1'b1, 1'b0, 1'b0, 1);
        cycles(1'b0, 1'b1, 1'b0, 1023);
        cycles(1'b0, 1'b1, 1'b1, 1);
        wait_done("drain_len_wrap_stop", 2049);
`ifdef VITERBI_SCHED_BLKCNT_EN
        check("blk_cnt_coincident", blk_cnt, 16'd1);
`endif
        cycles(1'b0, 1'b0, 1'b0, 2);

        // Reset mid-RUN with in_valid held high.
        cycles(1'b1, 1'b0, 1'b0, 1);
        cycles(1'b0, 1'b1, 1'b0, 3080);
        check("pre_reset_tbu_en", tbu_en, 2'b11);
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;
        in_valid = 1'b0;
        cycles(1'b0, 1'b0, 1'b0, 3);
        check("post_reset_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_bank_sched.md
# viterbi_bank_sched

Controller that sequences the four-bank trellis survivor memory of the Viterbi decoder. It generates per-bank write enables and addresses, the rotating write/read/idle bank roles, and the traceback unit enables and selects. It also sequences a start/fill/run/drain lifecycle so that the traceback units are flushed at end of stream. The block sits between the ACS array (survivor-vector valid strobe) and the trellis memories, the traceback units and the display-memory select.

## Interface
- `AW`, default 10: trellis memory address width; bank depth is 2^AW.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: begin a stream; sampled in IDLE only.
- `in_valid` in 1: a survivor vector is present this cycle.
- `stop` in 1: end of stream; sampled in FILL and RUN.
- `mem_wr` out 4: per-bank write enable; bit i is bank i (A=0 … D=3).
- `mem_addr` out 4*AW: per-bank address; bank i occupies `[i*AW +: AW]`.
- `tb_bank0` out 2: bank index feeding TBU input 0.
- `tb_bank1` out 2: bank index feeding TBU input 1.
- `tbu_en` out 2: traceback unit enables.
- `tbu_sel` out 2: traceback unit selection bits.
- `disp_sel` out 1: display memory bank select.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: single-cycle pulse when DRAIN completes.

## Operation
- **States:** IDLE, FILL, RUN, DRAIN, held in a 2-bit state register.
- **Counters:**
  - `wr_cnt` (AW bits) and `wb` (2-bit write bank) step when `step` is true.
  - `step` = `in_valid` in FILL/RUN, and = 1 every cycle in DRAIN.
  - Read address `rd_cnt` = ~`wr_cnt`, i.e. it descends from 2^AW−1.
  - When `wr_cnt` = 2^AW−1 and `step` is true, it is a *wrap*: `wr_cnt` → 0 and `wb` → `wb`+1 (mod 4).
- **Bank roles for write bank b:**
  - Bank b is written at `wr_cnt`.
  - Banks b+1 and b+3 are read at `rd_cnt`.
  - Bank b+2 is idle with address 0.
  - `mem_wr[b]` = `step` and state≠DRAIN; all other bits are 0.
- **Traceback mapping:**
  - `tb_bank0`, `tb_bank1` = b+3, b+2 when b is even; b+3, b+1 when b is odd (all mod 4).
  - `tbu_sel` = {~b[0], b[0]}.
  - `disp_sel` = b[0], delayed as specified in Timing.
- **Fill count:** `fill` is a 2-bit counter, saturating at 3, incremented on each wrap.
  - `tbu_en[0]` = (`fill` ≥ 2).
  - `tbu_en[1]` = (`fill` = 3).
  - Both are cleared only on entering IDLE.
- **Transitions:**
  - IDLE → FILL on `start`; this clears `wr_cnt`, `wb`, `fill` and `drain_cnt`.
  - FILL → RUN on the wrap that sets `fill` = 3.
  - FILL or RUN → DRAIN on `stop`. `drain_cnt` is cleared and the current bank position is retained.
  - DRAIN → IDLE on the second wrap counted in DRAIN; `done` pulses.
- **Boundary conditions:**
  - `stop` and wrap in the same cycle: the wrap is applied, then the state enters DRAIN. That wrap is not counted toward the drain.
  - `start` while busy is ignored. `stop` in IDLE or DRAIN is ignored.
  - `in_valid` in IDLE or DRAIN is ignored.
  - Reset mid-stream returns the block to IDLE immediately, with all outputs at reset values.

## Timing
- All outputs are registered. `mem_wr`, `mem_addr`, `tb_bank*` and `tbu_sel` reflect the `step` cycle one clock later.
- `disp_sel` lags `wb[0]` by 3 clocks, matching the traceback pipeline.
- `done` is asserted in the cycle after the final wrap; `busy` falls in that same cycle.
- **Reset values:**
  - state = IDLE.
  - `mem_wr` = 0 and `mem_addr` = 0.
  - `tb_bank0` = 3, `tb_bank1` = 2.
  - `tbu_en` = 0, `tbu_sel` = 2'b10, `disp_sel` = 0.
  - `busy` = 0, `done` = 0.
- There is no combinational path from any input to any output.

## Configuration
- **`VITERBI_SCHED_BLKCNT_EN` defined:** adds output `blk_cnt` (16 bits, reset 0).
  - It increments on every wrap outside DRAIN and wraps modulo 2^16.
  - It clears on IDLE → FILL.
- **Undefined:** the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `viterbi_pkg` holds:
  - the state enum `sched_state_t`;
  - the bank index constants `BANK_A` … `BANK_D`;
  - the default `AW`.
- One natural sub-module, `bank_role_map`: combinational mapping from b to the write, read and idle banks and to the TBU bank indices. The instance's outputs are registered in the parent.

## Test plan
- **Reset during RUN with `in_valid` held high:** all outputs go to reset values the same cycle; `busy` = 0.
- **`start` then 3×2^AW `in_valid` cycles:** `tbu_en` goes 00 → 01 after the 2nd wrap and → 11 after the 3rd; the state is RUN; `wb` = 3.
- **Addressing in `wb` = 0 at `wr_cnt` = 5:**
  - The next cycle shows `mem_wr` = 0001.
  - Bank A address = 5; banks B and D address = 1018; bank C address = 0.
  - (Numeric values assume `AW` = 10.)
- **Gapped `in_valid` (1 of 3 cycles):** `wr_cnt` advances only on valid cycles; `mem_wr` pulses once per valid.
- **`stop` in RUN at `wr_cnt` = 100:**
  - DRAIN free-runs with `mem_wr` = 0.
  - `done` pulses exactly (2^AW−101) + 2^AW + 1 cycles later; then IDLE.
- **`stop` coincident with a wrap:** that wrap is not counted; `done` follows after 2×2^AW further cycles. With the macro defined, `blk_cnt` includes the coincident wrap.
